// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment driver: sequential binary-to-BCD, atomic commit, tick-driven scan.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg_scan_mux #(
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 8,
    parameter int DIG_PER_CH = 3,
    parameter int PRESCALE   = 65536
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic [NUM_CH*CH_W-1:0]           val,
    output logic                             busy,
    output logic [NUM_CH-1:0]                ovf,
    output logic [6:0]                       sseg,
    output logic [NUM_CH*(DIG_PER_CH+1)-1:0] an
);

    localparam int NPOS = NUM_CH * (DIG_PER_CH + 1);
    // floor(CH_W*log10(2))+1 = decimal digits of 2^CH_W-1
    localparam int NDIG = (CH_W * 30103) / 100000 + 1;
    localparam int SD   = (NDIG > DIG_PER_CH) ? NDIG : DIG_PER_CH;
    localparam int SW   = SD * 4;
    localparam int DW   = DIG_PER_CH * 4;
    localparam int CW   = $clog2(PRESCALE);
    localparam int IW   = $clog2(NPOS);
    localparam int BW   = $clog2(CH_W + 1);
    localparam int PW   = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic [NUM_CH-1:0]       ovf_q;
    logic [PW-1:0]           ptr_q;
    logic [BW-1:0]           bcnt_q;
    logic [NUM_CH*CH_W-1:0]  snap_q;
    logic [CH_W-1:0]         cur_q;
    logic [SW-1:0]           bcd_q;
    logic [SW-1:0]           res_q  [NUM_CH];
    logic [DW-1:0]           disp_q [NUM_CH];

    logic [SW-1:0]           bcd_adj;
    logic [SW-1:0]           bcd_d;
    logic [CH_W-1:0]         chan_d;
    logic                    last_bit;
    logic                    last_ch;

    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    logic [NPOS-1:0]         an_q;
    logic [6:0]              sseg_q;
    logic                    tick;
    logic [NPOS-1:0]         an_d;
    logic [6:0]              seg_d;
    logic                    lz;

    function automatic logic [6:0] seg_dec(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < SD; i++) begin
            if (bcd_adj[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[SW-2:0], cur_q[CH_W-1]};
    end

    always_comb begin
        chan_d = '0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            if (ptr_q == PW'(k))
                chan_d = snap_q[(k+1)*CH_W +: CH_W];
        end
    end

    assign last_bit = (bcnt_q == BW'(CH_W - 1));
    assign last_ch  = (ptr_q == PW'(NUM_CH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
            snap_q  <= '0;
            cur_q   <= '0;
            bcd_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                res_q[k]  <= '0;
                disp_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        snap_q  <= val;
                        cur_q   <= val[CH_W-1:0];
                        ptr_q   <= '0;
                        bcnt_q  <= '0;
                        bcd_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (last_bit) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ptr_q == PW'(k))
                                res_q[k] <= bcd_d;
                        end
                        bcd_q  <= '0;
                        bcnt_q <= '0;
                        cur_q  <= chan_d;
                        ptr_q  <= ptr_q + 1'b1;
                        if (last_ch)
                            state_q <= COMMIT;
                    end else begin
                        bcd_q  <= bcd_d;
                        bcnt_q <= bcnt_q + 1'b1;
                        cur_q  <= cur_q << 1;
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        disp_q[k] <= res_q[k][DW-1:0];
                        ovf_q[k]  <= (res_q[k] >> DW) != '0;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tick = (cnt_q == CW'(PRESCALE - 1));
    assign an_d = ~(NPOS'(1) << idx_q);

    always_comb begin
        seg_d = 7'h7F;
        lz    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IW'(k*(DIG_PER_CH+1) + DIG_PER_CH))
                seg_d = seg_dec(4'(10 + k));
            for (int d = 0; d < DIG_PER_CH; d++) begin
                if (idx_q == IW'(k*(DIG_PER_CH+1) + d)) begin
`ifdef LEADING_ZERO_BLANK_EN
                    lz = (d != 0) && ((disp_q[k] >> (d*4)) == '0);
`else
                    lz = 1'b0;
`endif
                    if (ovf_q[k])
                        seg_d = 7'h3F;
                    else if (lz)
                        seg_d = 7'h7F;
                    else
                        seg_d = seg_dec(disp_q[k][d*4 +: 4]);
                end
            end
        end
    end

    // The scan shows the current index, then advances it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            sseg_q <= 7'h7F;
        end else if (tick) begin
            cnt_q  <= '0;
            an_q   <= an_d;
            sseg_q <= seg_d;
            idx_q  <= (idx_q == IW'(NPOS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign sseg = sseg_q;
    assign an   = an_q;

endmodule
